// File: rtl/flash_loader.sv
// rtl/flash_loader.sv - boot copier from SPI flash (mode 0 sequential read) into the cache write port
// FLASH_LOADER_FAST_READ_EN selects fast read 0x0B with 8 dummy clocks; default is read 0x03.
module flash_loader #(
  parameter int unsigned STARTUP_WAIT   = 1_000_000,
  parameter int unsigned CLK_DIV        = 1,
  parameter logic [23:0] FLASH_START    = 24'h0,
  parameter logic [31:0] RAM_START      = 32'h0,
  parameter logic [31:0] TRANSFER_BYTES = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        ready,
  output logic [31:0] cache_address,
  output logic [31:0] cache_data_in,
  output logic [3:0]  cache_write_enable,
  input  logic        cache_busy,
  output logic        flash_clk,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic        flash_cs
);

`ifdef FLASH_LOADER_FAST_READ_EN
  localparam logic [7:0] READ_CMD = 8'h0B;
`else
  localparam logic [7:0] READ_CMD = 8'h03;
`endif
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  localparam logic [3:0] S_POWER_WAIT = 4'd0;
  localparam logic [3:0] S_READY      = 4'd1;
  localparam logic [3:0] S_CMD        = 4'd2;
  localparam logic [3:0] S_ADDR       = 4'd3;
  localparam logic [3:0] S_DUMMY      = 4'd4;
  localparam logic [3:0] S_READ       = 4'd5;
  localparam logic [3:0] S_WRITE      = 4'd6;
  localparam logic [3:0] S_WRITE_WAIT = 4'd7;
  localparam logic [3:0] S_DONE       = 4'd8;

  logic [3:0]  state_q, state_d;
  logic [31:0] wait_q, wait_d;
  logic [7:0]  div_q, div_d;
  logic        sclk_q, sclk_d, mosi_q, mosi_d, cs_q, cs_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  lane_q, lane_d;
  logic [31:0] remain_q, remain_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  we_q, we_d;
  logic        first_q, first_d, busy_q, busy_d, done_q, done_d, ready_q, ready_d;

  logic       tick, shifting, phase_end, hold_ok;
  logic [4:0] bit_next;
  logic [3:0] tail_mask;

  always_comb begin
    state_d = state_q;  wait_d = wait_q;   div_d = div_q;     sclk_d = sclk_q;
    mosi_d = mosi_q;    cs_d = cs_q;       bit_d = bit_q;     tx_d = tx_q;
    rx_d = rx_q;        word_d = word_q;   lane_d = lane_q;   remain_d = remain_q;
    addr_d = addr_q;    wdata_d = wdata_q; we_d = we_q;       first_d = first_q;
    busy_d = busy_q;    done_d = done_q;

    tick      = (div_q == DIV_LAST);
    shifting  = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DUMMY) || (state_q == S_READ);
    phase_end = shifting && tick && sclk_q;
    hold_ok   = (div_q >= DIV_LAST);
    bit_next  = bit_q + 5'd1;

    case (lane_q)
      3'd1:    tail_mask = 4'b0001;
      3'd2:    tail_mask = 4'b0011;
      3'd3:    tail_mask = 4'b0111;
      default: tail_mask = 4'b1111;
    endcase

    // Shared SCLK engine: rising edge samples MISO, falling edge presents the next MOSI bit.
    if (shifting) begin
      if (tick) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        div_d = div_q + 8'd1;
      end
      if (tick && !sclk_q) rx_d = {rx_q[6:0], flash_miso};
      if (phase_end) begin
        mosi_d = tx_q[31];
        tx_d   = {tx_q[30:0], 1'b0};
        bit_d  = bit_next;
      end
    end else if ((state_q == S_WRITE) || (state_q == S_WRITE_WAIT)) begin
      // Keeps counting from the last falling edge so CS release can honour the SCLK-low hold.
      if (div_q != 8'hFF) div_d = div_q + 8'd1;
    end

    case (state_q)
      S_POWER_WAIT: begin
        if (wait_q >= STARTUP_WAIT) state_d = S_READY;
        else wait_d = wait_q + 32'd1;
      end
      S_READY: begin
        if (start) begin
          addr_d   = RAM_START;
          remain_d = TRANSFER_BYTES;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          if (TRANSFER_BYTES == 32'd0) begin
            state_d = S_DONE;
          end else begin
            cs_d    = 1'b0;
            mosi_d  = READ_CMD[7];
            tx_d    = {READ_CMD[6:0], FLASH_START, 1'b0};
            div_d   = '0;
            sclk_d  = 1'b0;
            bit_d   = '0;
            lane_d  = '0;
            word_d  = '0;
            state_d = S_CMD;
          end
        end
      end
      S_CMD: if (phase_end && bit_next == 5'd8) begin
        bit_d   = '0;
        state_d = S_ADDR;
      end
      S_ADDR: if (phase_end && bit_next == 5'd24) begin
        bit_d = '0;
`ifdef FLASH_LOADER_FAST_READ_EN
        state_d = S_DUMMY;
`else
        state_d = S_READ;
`endif
      end
      S_DUMMY: if (phase_end && bit_next == 5'd8) begin
        bit_d   = '0;
        state_d = S_READ;
      end
      S_READ: if (phase_end && bit_next == 5'd8) begin
        bit_d    = '0;
        word_d[{lane_q[1:0], 3'b000} +: 8] = rx_q;
        lane_d   = lane_q + 3'd1;
        remain_d = remain_q - 32'd1;
        if (lane_q == 3'd3 || remain_q == 32'd1) state_d = S_WRITE;
      end
      S_WRITE: if (!cache_busy) begin
        wdata_d = word_q;
        we_d    = tail_mask;
        first_d = 1'b1;
        state_d = S_WRITE_WAIT;
      end
      S_WRITE_WAIT: begin
        first_d = 1'b0;
        if (we_q != 4'd0) begin
          if (!cache_busy && !first_q) begin
            we_d   = 4'd0;
            addr_d = addr_q + 32'd4;
            if (remain_q != 32'd0) begin
              div_d   = '0;
              lane_d  = '0;
              word_d  = '0;
              state_d = S_READ;
            end else if (hold_ok) begin
              cs_d    = 1'b1;
              state_d = S_DONE;
            end
          end
        end else if (hold_ok) begin
          cs_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_READY;
      end
      default: state_d = S_POWER_WAIT;
    endcase

    ready_d = (state_d == S_READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_POWER_WAIT; wait_q <= '0;  div_q <= '0;    sclk_q <= 1'b0;
      mosi_q <= 1'b0;          cs_q <= 1'b1;  bit_q <= '0;    tx_q <= '0;
      rx_q <= '0;              word_q <= '0;  lane_q <= '0;   remain_q <= '0;
      addr_q <= '0;            wdata_q <= '0; we_q <= '0;     first_q <= 1'b0;
      busy_q <= 1'b0;          done_q <= 1'b0; ready_q <= 1'b0;
    end else begin
      state_q <= state_d;      wait_q <= wait_d;   div_q <= div_d;     sclk_q <= sclk_d;
      mosi_q <= mosi_d;        cs_q <= cs_d;       bit_q <= bit_d;     tx_q <= tx_d;
      rx_q <= rx_d;            word_q <= word_d;   lane_q <= lane_d;   remain_q <= remain_d;
      addr_q <= addr_d;        wdata_q <= wdata_d; we_q <= we_d;       first_q <= first_d;
      busy_q <= busy_d;        done_q <= done_d;   ready_q <= ready_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign ready              = ready_q;
  assign cache_address      = addr_q;
  assign cache_data_in      = wdata_q;
  assign cache_write_enable = we_q;
  assign flash_clk          = sclk_q;
  assign flash_mosi         = mosi_q;
  assign flash_cs           = cs_q;

endmodule

// File: tb/tb_flash_loader.sv
// tb/tb_flash_loader.sv - randomized flash contents and cache backpressure against a byte-level copy model
module tb_flash_loader;
  localparam int          STARTUP_WAIT = 40;
  localparam int          CLK_DIV      = 3;
  localparam logic [23:0] FLASH_START  = 24'h000025;
  localparam logic [31:0] RAM_START    = 32'hFFFF_FFF8;
  localparam int          N_BYTES      = 14;
`ifdef FLASH_LOADER_FAST_READ_EN
  localparam int          HDR_BITS = 40;
  localparam logic [7:0]  EXP_CMD  = 8'h0B;
`else
  localparam int          HDR_BITS = 32;
  localparam logic [7:0]  EXP_CMD  = 8'h03;
`endif

  logic clk = 1'b0;
  logic rst, start, busy, done, ready, cache_busy, flash_clk, flash_mosi, flash_cs;
  logic flash_miso = 1'b0;
  logic [31:0] cache_address, cache_data_in;
  logic [3:0]  cache_write_enable;
  logic z_start, z_busy, z_done, z_ready, z_flash_clk, z_flash_mosi, z_flash_cs;
  logic [31:0] z_cache_address, z_cache_data_in;
  logic [3:0]  z_cache_write_enable;

  always #5 clk = ~clk;

  flash_loader #(.STARTUP_WAIT(STARTUP_WAIT), .CLK_DIV(CLK_DIV), .FLASH_START(FLASH_START),
                 .RAM_START(RAM_START), .TRANSFER_BYTES(32'(N_BYTES))) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .ready(ready),
    .cache_address(cache_address), .cache_data_in(cache_data_in),
    .cache_write_enable(cache_write_enable), .cache_busy(cache_busy),
    .flash_clk(flash_clk), .flash_mosi(flash_mosi), .flash_miso(flash_miso), .flash_cs(flash_cs));

  flash_loader #(.STARTUP_WAIT(5), .CLK_DIV(2), .FLASH_START(24'h0),
                 .RAM_START(32'h100), .TRANSFER_BYTES(32'd0)) u_zero (
    .clk(clk), .rst(rst), .start(z_start), .busy(z_busy), .done(z_done), .ready(z_ready),
    .cache_address(z_cache_address), .cache_data_in(z_cache_data_in),
    .cache_write_enable(z_cache_write_enable), .cache_busy(1'b0),
    .flash_clk(z_flash_clk), .flash_mosi(z_flash_mosi), .flash_miso(1'b0), .flash_cs(z_flash_cs));

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // SPI flash model: header capture, then sequential bytes MSB first, updated on SCLK falling edges
  logic [7:0]  mem [256];
  logic [31:0] hdr;
  int          rcnt;
  bit          dummy_bad;

  always @(negedge flash_cs) begin
    rcnt = 0; hdr = '0; dummy_bad = 0;
  end

  always @(posedge flash_clk) begin
    if (!flash_cs) begin
      if (rcnt < 32) hdr = {hdr[30:0], flash_mosi};
      else if (rcnt < HDR_BITS) dummy_bad = dummy_bad | flash_mosi;
      rcnt++;
    end
  end

  always @(negedge flash_clk) begin : flash_out
    int k;
    logic [7:0] fb;
    if (!flash_cs && rcnt >= HDR_BITS) begin
      k = rcnt - HDR_BITS;
      fb = mem[8'(hdr[23:0] + 24'(k / 8))];
      flash_miso = fb[7 - (k % 8)];
    end
  end

  // Cache-side monitor and busy driver, plus SPI timing observations
  int          cyc = 0, hold = 0, held = 0, busy_mode = 0, cs_fall_cyc = 0, sclk_fall_cyc = 0;
  bit          need_rise = 0, mosi_bad = 0, sclk_in_write = 0, skip_cs = 0, z_cs_low = 0, z_we_seen = 0;
  logic [31:0] got_addr [$];
  logic [31:0] got_data [$];
  logic [3:0]  got_we [$];
  logic        prev_sclk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;
  logic [3:0]  prev_we = 4'd0;

  initial begin
    cache_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cache_write_enable != 4'd0) begin
        if (prev_we == 4'd0) begin
          got_addr.push_back(cache_address);
          got_data.push_back(cache_data_in);
          got_we.push_back(cache_write_enable);
          held = 0;
          if (busy_mode == 2) hold = 20;
        end
        held++;
        if (flash_clk) sclk_in_write = 1;
      end else if (prev_we != 4'd0 && busy_mode == 2) begin
        check_eq("bp_hold", 32'(held >= 20), 32'd1);
      end
      if (hold > 0) begin
        cache_busy = 1'b1;
        hold--;
      end else if (busy_mode == 1) begin
        cache_busy = ($urandom_range(0, 3) == 0);
      end else begin
        cache_busy = 1'b0;
      end
      if (prev_cs && !flash_cs) begin
        cs_fall_cyc = cyc;
        need_rise = 1;
      end
      if (!prev_sclk && flash_clk && need_rise) begin
        check_eq("first_sclk", 32'((cyc - cs_fall_cyc) <= CLK_DIV + 1), 32'd1);
        need_rise = 0;
      end
      if (prev_sclk && !flash_clk) sclk_fall_cyc = cyc;
      if (!prev_cs && flash_cs && !skip_cs)
        check_eq("cs_hold", 32'((cyc - sclk_fall_cyc) >= CLK_DIV), 32'd1);
      if ((flash_mosi !== prev_mosi) && !(prev_sclk && !flash_clk) && !(prev_cs && !flash_cs))
        mosi_bad = 1;
      if (!z_flash_cs) z_cs_low = 1;
      if (z_cache_write_enable != 4'd0) z_we_seen = 1;
      prev_sclk = flash_clk;
      prev_cs   = flash_cs;
      prev_mosi = flash_mosi;
      prev_we   = cache_write_enable;
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < STARTUP_WAIT + 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_copy(input int mode);
    int n, nw;
    logic [31:0] ea, ed;
    logic [3:0]  ew;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    busy_mode = mode;
    got_addr.delete(); got_data.delete(); got_we.delete();
    mosi_bad = 0; sclk_in_write = 0;
    wait_ready(n);
    check_eq("ready_before_start", 32'(ready), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_on_start", 32'(busy), 32'd1);
    check_eq("done_cleared", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_reached", 32'(done), 32'd1);
    check_eq("cs_released", 32'(flash_cs), 32'd1);
    check_eq("busy_off", 32'(busy), 32'd0);
    nw = (N_BYTES + 3) / 4;
    check_eq("write_count", 32'(got_addr.size()), 32'(nw));
    for (int w = 0; w < nw && w < got_addr.size(); w++) begin
      ea = RAM_START + 32'(4 * w);
      ed = '0;
      ew = '0;
      for (int b = 0; b < 4; b++) begin
        if (4 * w + b < N_BYTES) begin
          ed = ed | (32'(mem[8'(FLASH_START + 24'(4 * w + b))]) << (8 * b));
          ew[b] = 1'b1;
        end
      end
      check_eq("wr_addr", got_addr[w], ea);
      check_eq("wr_data", got_data[w], ed);
      check_eq("wr_strobe", 32'(got_we[w]), 32'(ew));
    end
    check_eq("cmd_byte", 32'(hdr[31:24]), 32'(EXP_CMD));
    check_eq("flash_addr", 32'(hdr[23:0]), 32'(FLASH_START));
    check_eq("sclk_count", 32'(rcnt), 32'(HDR_BITS + 8 * N_BYTES));
    check_eq("dummy_mosi", 32'(dummy_bad), 32'd0);
    check_eq("mosi_timing", 32'(mosi_bad), 32'd0);
    check_eq("sclk_idle_write", 32'(sclk_in_write), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("done_sticky", 32'(done), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; z_start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_cs", 32'(flash_cs), 32'd1);
    check_eq("rst_sclk", 32'(flash_clk), 32'd0);
    check_eq("rst_mosi", 32'(flash_mosi), 32'd0);
    check_eq("rst_strobe", 32'(cache_write_enable), 32'd0);
    check_eq("rst_addr", cache_address, 32'd0);
    check_eq("rst_data", cache_data_in, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    wait_ready(n);
    check_eq("startup_wait", 32'(n >= STARTUP_WAIT && n <= STARTUP_WAIT + 2), 32'd1);

    check_eq("zero_ready", 32'(z_ready), 32'd1);
    z_start = 1'b1;
    @(negedge clk);
    z_start = 1'b0;
    check_eq("zero_busy", 32'(z_busy), 32'd1);
    @(negedge clk);
    check_eq("zero_done", 32'(z_done), 32'd1);

    run_copy(0);
    run_copy(2);
    run_copy(1);

    busy_mode = 0;
    got_addr.delete(); got_data.delete(); got_we.delete();
    wait_ready(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (got_addr.size() < 2 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_reach_word3", 32'(got_addr.size()), 32'd2);
    repeat (40) @(negedge clk);
    skip_cs = 1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_cs", 32'(flash_cs), 32'd1);
    check_eq("midrst_strobe", 32'(cache_write_enable), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_ready", 32'(ready), 32'd0);
    check_eq("midrst_sclk", 32'(flash_clk), 32'd0);
    rst = 1'b0;
    wait_ready(n);
    skip_cs = 0;
    check_eq("midrst_startup", 32'(n >= STARTUP_WAIT && n <= STARTUP_WAIT + 2), 32'd1);

    run_copy(2);

    check_eq("zero_no_cs", 32'(z_cs_low), 32'd0);
    check_eq("zero_no_write", 32'(z_we_seen), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
